sti_rx_deserializer: RTL and testbench
======================================

# sti_rx_deserializer

Serial-to-parallel receiver for the STI serial link: it samples the `si_data`/`si_valid` bit stream and rebuilds the 16-bit parallel word. Frame framing is fixed by the 2-bit length code plus the msb/low/fill controls. The block sits at the far end of the serial link, opposite the parallel-to-serial transmitter. It returns recovered words to the host side with a one-cycle valid pulse, a pad-error flag, an abort pulse and a frame counter.

## Interface
- No parameters; all widths fixed.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `si_data` input 1: serial bit, sampled only while `si_valid`=1.
- `si_valid` input 1: frame envelope; high for exactly N contiguous cycles per frame.
- `cfg_length` input 2: frame length code; 00=8, 01=16, 10=24, 11=32 bits.
- `cfg_msb` input 1: 1 = first serial bit is the word MSB; 0 = LSB first.
- `cfg_low` input 1: 8-bit frames only; 1 = byte lands in `po_data[15:8]`, 0 = `[7:0]`.
- `cfg_fill` input 1: 24/32-bit frames only; 1 = data in the upper 16 bits of the N-bit word, 0 = the lower 16.
- `po_data` output 16: recovered word; holds its value until the next delivery.
- `po_valid` output 1: one-cycle pulse; `po_data` is new.
- `po_perr` output 1: qualified by `po_valid`; nonzero pad bit was seen in the frame.
- `po_abort` output 1: one-cycle pulse; frame truncated and discarded.
- `busy` output 1: high while a frame is being received.
- `frame_cnt` output 8: count of delivered frames; wraps 255→0.

## Operation
- States: IDLE, RECV.
- **IDLE**
  - On a cycle with `si_valid`=1, latch `cfg_*`, store that bit as bit index 0, set bit counter to 1 and go to RECV.
  - The N=1 case does not exist.
- **RECV**, each cycle:
  - `si_valid`=1: store the bit at index = counter and increment the counter.
  - When the counter reaches N (last bit stored), deliver the frame and return to IDLE.
  - `si_valid`=0 before N bits: discard the frame, pulse `po_abort` and return to IDLE.
- Word assembly: W is an N-bit word. Serial index k maps to W[N-1-k] if msb=1, else W[k].
- Extraction:
  - N=8: `po_data` = low ? {W[7:0],8'h00} : {8'h00,W[7:0]}.
  - N=16: `po_data` = W[15:0].
  - N=24/32: `po_data` = fill ? W[N-1:N-16] : W[15:0]. The remaining N-16 bits are pad; `po_perr` = OR of the pad bits.
- `po_perr`=0 for N=8 and N=16.
- Configuration changes during RECV are ignored; the latched cfg governs the whole frame.
- Back-to-back frames: if `si_valid` stays high in the cycle after the last bit, that cycle is bit 0 of a new frame. The new frame re-latches cfg, and delivery and the new capture coexist.
- `frame_cnt` increments on each `po_valid`; aborts do not count.

## Timing
- Reset (asynchronous, `reset`=0):
  - `po_data`=0, `po_valid`=0, `po_perr`=0, `po_abort`=0, `busy`=0, `frame_cnt`=0.
  - State IDLE, counter 0, shift storage cleared.
- Reset mid-frame discards the partial frame; no `po_valid` or `po_abort` pulse follows.
- Latency: `po_valid`, `po_data`, `po_perr` and `frame_cnt` update on the rising edge that samples the last bit. They are visible in the following cycle.
- `po_valid` is high for exactly 1 cycle.
- `po_abort` updates on the edge that samples `si_valid`=0 in RECV; it is high for 1 cycle.
- `busy`=1 from the edge after bit 0 through the edge that samples the last bit or the abort; `busy` is registered.
- Throughput: one frame per N cycles, with zero idle cycles required between frames.

## Test plan
- 16-bit, msb=1, bits of 0xA5C3 sent MSB first → `po_data`=0xA5C3 and `po_valid` pulse one cycle after bit 15; `frame_cnt`=1.
- 8-bit, msb=0, low=1, bits 1,0,0,0,0,0,0,1 → `po_data`=0x8100, `po_perr`=0.
- 24-bit, msb=0, fill=1: eight 0s, then 0x1234 LSB first → `po_data`=0x1234, `po_perr`=0.
- 32-bit, msb=1, fill=0: 16 pad bits with pad bit 3 = 1, then 0xBEEF MSB first → `po_data`=0xBEEF, `po_perr`=1.
- Abort and reset handling:
  - 16-bit frame with `si_valid` dropped after 5 bits → `po_abort` one pulse, no `po_valid`, `frame_cnt` unchanged.
  - Next full frame delivered correctly.
  - `reset` asserted mid-frame → all outputs 0.
- Back-to-back: 8-bit 0x5A (msb=1), then 16-bit 0x0F0F (msb=0) with `si_valid` continuous for 24 cycles and cfg switched at the boundary:
  - `po_data`=0x005A after cycle 8, then 0x0F0F after cycle 24.
  - `frame_cnt`=2.
  - 256 total frames wrap `frame_cnt` to 0.

Source files
------------

// File: rtl/sti_rx_deserializer.sv
// STI serial-link receiver: rebuilds 8/16/24/32-bit frames from si_data/si_valid
// and delivers the 16-bit payload with pad-error, abort and frame-count status.
module sti_rx_deserializer (
  input  logic        clk,
  input  logic        reset,
  input  logic        si_data,
  input  logic        si_valid,
  input  logic [1:0]  cfg_length,
  input  logic        cfg_msb,
  input  logic        cfg_low,
  input  logic        cfg_fill,
  output logic [15:0] po_data,
  output logic        po_valid,
  output logic        po_perr,
  output logic        po_abort,
  output logic        busy,
  output logic [7:0]  frame_cnt
);

  typedef enum logic {S_IDLE = 1'b0, S_RECV = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] raw_q, raw_d;
  logic [1:0]  len_q, len_d;
  logic        msb_q, msb_d;
  logic        low_q, low_d;
  logic        fill_q, fill_d;

  logic [15:0] po_data_q, po_data_d;
  logic        po_valid_q, po_valid_d;
  logic        po_perr_q, po_perr_d;
  logic        po_abort_q, po_abort_d;
  logic        busy_q, busy_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;

  logic [4:0]  nm1_s;
  logic        last_bit_s;
  logic        abort_s;
  logic [31:0] raw_full_s;
  logic [31:0] word_s;
  logic [15:0] data_s;
  logic        perr_s;

  // Map serial-order bits onto the N-bit word; bits at or above N read as zero.
  function automatic logic [31:0] assemble_word(input logic [31:0] raw,
                                                input logic [4:0]  nm1,
                                                input logic        msb);
    logic [31:0] w;
    logic [4:0]  ii;
    w = 32'h0000_0000;
    for (int i = 0; i < 32; i++) begin
      ii = 5'(i);
      if (ii <= nm1) begin
        if (msb) begin
          w[ii] = raw[nm1 - ii];
        end else begin
          w[ii] = raw[ii];
        end
      end else begin
        w[ii] = 1'b0;
      end
    end
    return w;
  endfunction

  function automatic logic pad_error(input logic [31:0] w,
                                     input logic [1:0]  len,
                                     input logic        fill);
    logic e;
    case (len)
      2'b10:   e = fill ? (|w[7:0])  : (|w[23:16]);
      2'b11:   e = fill ? (|w[15:0]) : (|w[31:16]);
      default: e = 1'b0;
    endcase
    return e;
  endfunction

  assign nm1_s      = {len_q, 3'b111};
  assign last_bit_s = (state_q == S_RECV) && si_valid && (cnt_q == nm1_s);
  assign abort_s    = (state_q == S_RECV) && !si_valid;

  // Frame word including the bit sampled this cycle, and its payload/pad view.
  always_comb begin
    raw_full_s        = raw_q;
    raw_full_s[cnt_q] = si_data;
    word_s            = assemble_word(raw_full_s, nm1_s, msb_q);
    perr_s            = pad_error(word_s, len_q, fill_q);
    case (len_q)
      2'b00:   data_s = low_q ? {word_s[7:0], 8'h00} : {8'h00, word_s[7:0]};
      2'b01:   data_s = word_s[15:0];
      2'b10:   data_s = fill_q ? word_s[23:8] : word_s[15:0];
      2'b11:   data_s = fill_q ? word_s[31:16] : word_s[15:0];
      default: data_s = 16'h0000;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (si_valid) begin
          state_d = S_RECV;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RECV: begin
        if (!si_valid || (cnt_q == nm1_s)) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RECV;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Capture datapath: bit counter, serial storage and per-frame configuration.
  always_comb begin
    cnt_d  = cnt_q;
    raw_d  = raw_q;
    len_d  = len_q;
    msb_d  = msb_q;
    low_d  = low_q;
    fill_d = fill_q;
    case (state_q)
      S_IDLE: begin
        if (si_valid) begin
          cnt_d  = 5'd1;
          raw_d  = {31'h0000_0000, si_data};
          len_d  = cfg_length;
          msb_d  = cfg_msb;
          low_d  = cfg_low;
          fill_d = cfg_fill;
        end else begin
          cnt_d = 5'd0;
        end
      end
      S_RECV: begin
        if (si_valid && !last_bit_s) begin
          cnt_d = cnt_q + 5'd1;
          raw_d = raw_full_s;
        end else begin
          cnt_d = 5'd0;
          raw_d = 32'h0000_0000;
        end
      end
      default: begin
        cnt_d = 5'd0;
        raw_d = 32'h0000_0000;
      end
    endcase
  end

  // FSM output logic; everything below is registered before leaving the block.
  always_comb begin
    po_valid_d  = last_bit_s;
    po_abort_d  = abort_s;
    busy_d      = (state_d == S_RECV);
    po_data_d   = po_data_q;
    po_perr_d   = po_perr_q;
    frame_cnt_d = frame_cnt_q;
    if (last_bit_s) begin
      po_data_d   = data_s;
      po_perr_d   = perr_s;
      frame_cnt_d = frame_cnt_q + 8'd1;
    end else begin
      po_data_d   = po_data_q;
      po_perr_d   = po_perr_q;
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= 5'd0;
      raw_q       <= 32'h0000_0000;
      len_q       <= 2'b00;
      msb_q       <= 1'b0;
      low_q       <= 1'b0;
      fill_q      <= 1'b0;
      po_data_q   <= 16'h0000;
      po_valid_q  <= 1'b0;
      po_perr_q   <= 1'b0;
      po_abort_q  <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      cnt_q       <= cnt_d;
      raw_q       <= raw_d;
      len_q       <= len_d;
      msb_q       <= msb_d;
      low_q       <= low_d;
      fill_q      <= fill_d;
      po_data_q   <= po_data_d;
      po_valid_q  <= po_valid_d;
      po_perr_q   <= po_perr_d;
      po_abort_q  <= po_abort_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign po_data   = po_data_q;
  assign po_valid  = po_valid_q;
  assign po_perr   = po_perr_q;
  assign po_abort  = po_abort_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_sti_rx_deserializer.sv
// Directed, table-driven bench for sti_rx_deserializer: frame formats, pad errors,
// abort, mid-frame reset, back-to-back frames and frame counter wrap.
module tb_sti_rx_deserializer;

  logic        clk;
  logic        reset;
  logic        si_data;
  logic        si_valid;
  logic [1:0]  cfg_length;
  logic        cfg_msb;
  logic        cfg_low;
  logic        cfg_fill;
  logic [15:0] po_data;
  logic        po_valid;
  logic        po_perr;
  logic        po_abort;
  logic        busy;
  logic [7:0]  frame_cnt;

  int          checks;
  int          failures;
  logic [7:0]  exp_cnt;

  typedef struct {
    logic [1:0]  len;
    logic        msb;
    logic        low;
    logic        fill;
    logic [31:0] word;
    logic [15:0] exp_data;
    logic        exp_perr;
  } vec_t;

  vec_t vecs [10];

  sti_rx_deserializer dut (
    .clk        (clk),
    .reset      (reset),
    .si_data    (si_data),
    .si_valid   (si_valid),
    .cfg_length (cfg_length),
    .cfg_msb    (cfg_msb),
    .cfg_low    (cfg_low),
    .cfg_fill   (cfg_fill),
    .po_data    (po_data),
    .po_valid   (po_valid),
    .po_perr    (po_perr),
    .po_abort   (po_abort),
    .busy       (busy),
    .frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transmit nb bits of the N-bit word w; cfg is scrambled after bit 0.
  task automatic send_bits(input logic [1:0] len, input logic msb, input logic low,
                           input logic fill, input logic [31:0] w, input int nb);
    int         n;
    logic [4:0] idx;
    n = (int'(len) + 1) * 8;
    for (int k = 0; k < nb; k++) begin
      if (k == 0) begin
        cfg_length = len;  cfg_msb = msb;  cfg_low = low;  cfg_fill = fill;
      end else begin
        cfg_length = ~len; cfg_msb = ~msb; cfg_low = ~low; cfg_fill = ~fill;
      end
      idx      = msb ? 5'(n - 1 - k) : 5'(k);
      si_valid = 1'b1;
      si_data  = w[idx];
      @(posedge clk); #1;
    end
  endtask

  task automatic idle_cycle();
    si_valid = 1'b0;
    si_data  = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_cnt  = 8'd0;
    reset    = 1'b0;
    si_data  = 1'b0;
    si_valid = 1'b0;
    cfg_length = 2'b00; cfg_msb = 1'b0; cfg_low = 1'b0; cfg_fill = 1'b0;

    vecs[0] = '{2'b01, 1'b1, 1'b0, 1'b0, 32'h0000_A5C3, 16'hA5C3, 1'b0};
    vecs[1] = '{2'b00, 1'b0, 1'b1, 1'b0, 32'h0000_0081, 16'h8100, 1'b0};
    vecs[2] = '{2'b10, 1'b0, 1'b0, 1'b1, 32'h0012_3400, 16'h1234, 1'b0};
    vecs[3] = '{2'b11, 1'b1, 1'b0, 1'b0, 32'h1000_BEEF, 16'hBEEF, 1'b1};
    vecs[4] = '{2'b01, 1'b0, 1'b0, 1'b0, 32'h0000_1357, 16'h1357, 1'b0};
    vecs[5] = '{2'b00, 1'b1, 1'b0, 1'b0, 32'h0000_003C, 16'h003C, 1'b0};
    vecs[6] = '{2'b10, 1'b1, 1'b0, 1'b0, 32'h00FF_ABCD, 16'hABCD, 1'b1};
    vecs[7] = '{2'b11, 1'b0, 1'b0, 1'b1, 32'hCAFE_0000, 16'hCAFE, 1'b0};
    vecs[8] = '{2'b10, 1'b1, 1'b0, 1'b1, 32'h0056_7801, 16'h5678, 1'b1};
    vecs[9] = '{2'b11, 1'b0, 1'b0, 1'b0, 32'h0000_8001, 16'h8001, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_po_data", 32'(po_data), 32'h0);
    chk("rst_po_valid", 32'(po_valid), 32'h0);
    chk("rst_po_perr", 32'(po_perr), 32'h0);
    chk("rst_po_abort", 32'(po_abort), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'h0);
    reset = 1'b1;
    idle_cycle();

    for (int i = 0; i < 10; i++) begin
      send_bits(vecs[i].len, vecs[i].msb, vecs[i].low, vecs[i].fill, vecs[i].word,
                (int'(vecs[i].len) + 1) * 8);
      exp_cnt = exp_cnt + 8'd1;
      chk($sformatf("v%0d_valid", i), 32'(po_valid), 32'h1);
      chk($sformatf("v%0d_data", i), 32'(po_data), 32'(vecs[i].exp_data));
      chk($sformatf("v%0d_perr", i), 32'(po_perr), 32'(vecs[i].exp_perr));
      chk($sformatf("v%0d_cnt", i), 32'(frame_cnt), 32'(exp_cnt));
      idle_cycle();
      chk($sformatf("v%0d_valid_pulse", i), 32'(po_valid), 32'h0);
      chk($sformatf("v%0d_busy_idle", i), 32'(busy), 32'h0);
      chk($sformatf("v%0d_data_hold", i), 32'(po_data), 32'(vecs[i].exp_data));
    end

    // Truncated 16-bit frame.
    send_bits(2'b01, 1'b1, 1'b0, 1'b0, 32'h0000_FFFF, 5);
    chk("abort_busy", 32'(busy), 32'h1);
    idle_cycle();
    chk("abort_pulse", 32'(po_abort), 32'h1);
    chk("abort_no_valid", 32'(po_valid), 32'h0);
    chk("abort_cnt", 32'(frame_cnt), 32'(exp_cnt));
    idle_cycle();
    chk("abort_one_cycle", 32'(po_abort), 32'h0);
    chk("abort_data_hold", 32'(po_data), 32'h8001);

    send_bits(2'b01, 1'b1, 1'b0, 1'b0, 32'h0000_2468, 16);
    exp_cnt = exp_cnt + 8'd1;
    chk("post_abort_valid", 32'(po_valid), 32'h1);
    chk("post_abort_data", 32'(po_data), 32'h2468);
    chk("post_abort_cnt", 32'(frame_cnt), 32'(exp_cnt));
    idle_cycle();

    // Reset in the middle of a frame.
    send_bits(2'b01, 1'b0, 1'b0, 1'b0, 32'h0000_FFFF, 7);
    reset = 1'b0;
    #1;
    chk("mid_rst_data", 32'(po_data), 32'h0);
    chk("mid_rst_valid", 32'(po_valid), 32'h0);
    chk("mid_rst_perr", 32'(po_perr), 32'h0);
    chk("mid_rst_abort", 32'(po_abort), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_cnt", 32'(frame_cnt), 32'h0);
    exp_cnt  = 8'd0;
    si_valid = 1'b0;
    si_data  = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      idle_cycle();
      chk("post_rst_no_valid", 32'(po_valid), 32'h0);
      chk("post_rst_no_abort", 32'(po_abort), 32'h0);
    end

    // Back-to-back: 8-bit 0x5A MSB first then 16-bit 0x0F0F LSB first.
    send_bits(2'b00, 1'b1, 1'b0, 1'b0, 32'h0000_005A, 8);
    chk("b2b_first_valid", 32'(po_valid), 32'h1);
    chk("b2b_first_data", 32'(po_data), 32'h005A);
    send_bits(2'b01, 1'b0, 1'b0, 1'b0, 32'h0000_0F0F, 16);
    chk("b2b_second_valid", 32'(po_valid), 32'h1);
    chk("b2b_second_data", 32'(po_data), 32'h0F0F);
    chk("b2b_cnt", 32'(frame_cnt), 32'h2);

    // Continue back-to-back until 256 frames have been delivered.
    for (int f = 0; f < 253; f++) begin
      send_bits(2'b00, 1'b0, 1'b0, 1'b0, 32'(f[7:0]), 8);
    end
    chk("wrap_cnt_255", 32'(frame_cnt), 32'hFF);
    chk("wrap_last_data", 32'(po_data), 32'h00FC);
    send_bits(2'b00, 1'b0, 1'b1, 1'b0, 32'h0000_00C7, 8);
    chk("wrap_valid", 32'(po_valid), 32'h1);
    chk("wrap_data", 32'(po_data), 32'hC700);
    chk("wrap_cnt_0", 32'(frame_cnt), 32'h0);
    idle_cycle();
    chk("wrap_busy_idle", 32'(busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
